viterbi_frame_ctrl: RTL

- Frame-level sequencer for the rate-1/2, K=3 Viterbi decoder front end.
- Accepts received symbol pairs over a valid/ready handshake and presents one pair per step to the three-stage branch-metric chain (first stage, second stage, steady-state stage).
- Aligns the ACS enable with the branch-metric pipeline latency, then launches traceback and issues the inter-frame refresh to the BMU chain.

---
 rtl/viterbi_frame_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the rate-1/2 K=3 Viterbi front end: accepts symbol pairs,
// feeds the branch-metric chain, aligns the ACS enable and launches traceback.
module viterbi_frame_ctrl #(
   parameter int FRAME_LEN = 16,
   parameter int PIPE_LAT  = 2,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sym_valid,
   input  logic [1:0]       sym_pair,
   output logic             sym_ready,
   input  logic             frame_abort,
   output logic [1:0]       bit_pair_out,
   output logic             pair_strobe,
   output logic [1:0]       stage_sel,
   output logic             bmu_refresh,
   output logic             acs_en,
   output logic             tb_start,
   input  logic             tb_done,
   output logic             frame_busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] step_cnt
);

   typedef enum logic [2:0] {IDLE, LOAD, DRAIN, TB, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(FRAME_LEN - 1);
   localparam logic [2:0]       LAST_DRAIN = 3'(PIPE_LAT);

   state_t              state;
   logic [2:0]          drain_cnt;
   logic [PIPE_LAT-1:0] acs_dly;
   logic                accept;
   logic                abort_hit;

   assign accept    = sym_valid & sym_ready & ~frame_abort;
   assign abort_hit = frame_abort & ((state == LOAD) | (state == DRAIN) | (state == TB));
   assign acs_en    = acs_dly[PIPE_LAT-1];

   // Only steady-stage pairs produce metrics the ACS consumes; the delay line
   // matches the branch-metric pipeline and is flushed when a frame is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acs_dly <= '0;
      end else if (abort_hit) begin
         acs_dly <= '0;
      end else begin
         acs_dly[0] <= pair_strobe & (stage_sel == 2'd2);
         for (int i = 1; i < PIPE_LAT; i++) begin
            acs_dly[i] <= acs_dly[i-1];
         end
      end
   end

   // Frame FSM; all outputs are registered and the pulses default low each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         drain_cnt    <= '0;
         sym_ready    <= 1'b0;
         bit_pair_out <= '0;
         pair_strobe  <= 1'b0;
         stage_sel    <= '0;
         bmu_refresh  <= 1'b0;
         tb_start     <= 1'b0;
         frame_busy   <= 1'b0;
         frame_done   <= 1'b0;
         step_cnt     <= '0;
      end else begin
         pair_strobe <= accept;
         tb_start    <= 1'b0;
         frame_done  <= 1'b0;
         bmu_refresh <= 1'b0;
         if (accept) begin
            bit_pair_out <= sym_pair;
            stage_sel    <= (step_cnt == '0) ? 2'd0 :
                            (step_cnt == CNT_W'(1)) ? 2'd1 : 2'd2;
         end
         if (abort_hit) begin
            state       <= IDLE;
            step_cnt    <= '0;
            sym_ready   <= 1'b1;
            bmu_refresh <= 1'b1;
            frame_busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  sym_ready <= 1'b1;
                  if (accept) begin
                     state      <= LOAD;
                     step_cnt   <= CNT_W'(1);
                     frame_busy <= 1'b1;
                  end
               end
               LOAD: begin
                  if (accept) begin
                     step_cnt <= step_cnt + 1'b1;
                     if (step_cnt == LAST_STEP) begin
                        sym_ready <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                     end
                  end
               end
               DRAIN: begin
                  // Counts PIPE_LAT+1 cycles from the edge that took the last pair.
                  if (drain_cnt == LAST_DRAIN) begin
                     state    <= TB;
                     tb_start <= 1'b1;
                  end else begin
                     drain_cnt <= drain_cnt + 1'b1;
                  end
               end
               TB: begin
                  if (tb_done) begin
                     state       <= DONE;
                     frame_done  <= 1'b1;
                     bmu_refresh <= 1'b1;
                  end
               end
               DONE: begin
                  state      <= IDLE;
                  sym_ready  <= 1'b1;
                  step_cnt   <= '0;
                  frame_busy <= 1'b0;
               end
               default: begin
                  state      <= IDLE;
                  frame_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
